// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM encoding and sizing helper for the bit-serial subtractor.
package serial_sub_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to count 0..value-1; never less than one bit
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return (res < 1) ? 1 : res;
  endfunction

endpackage

// File: rtl/half_sub_cell.sv
// half_sub_cell: one half-subtractor stage, d = x - y with borrow-out.
module half_sub_cell (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  // Difference and borrow of a single-bit subtraction
  always_comb begin
    d  = x ^ y;
    bo = ~x & y;
  end

endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial a - b, LSB first, one bit per clock.
// Optional build macro SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
import serial_sub_pkg::*;

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  , output logic           ovf
`endif
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, diff_reg;
  logic             bin_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic d1, b1, d_bit, b2, bout;
  logic accept, last_bit;

  // Full subtractor built from two half-subtractor stages
  half_sub_cell u_hs_ab (
    .x  (a_reg[0]),
    .y  (b_reg[0]),
    .d  (d1),
    .bo (b1)
  );

  half_sub_cell u_hs_bin (
    .x  (d1),
    .y  (bin_reg),
    .d  (d_bit),
    .bo (b2)
  );

  assign bout     = b1 | b2;
  assign accept   = (state_reg == IDLE) && start;
  assign last_bit = (state_reg == SHIFT) && (cnt_reg == LAST_BIT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; start is only looked at in IDLE, so a busy start is dropped
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt_reg == LAST_BIT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state
  always_comb begin
    busy = (state_reg == SHIFT) || (state_reg == DONE);
    done = (state_reg == DONE);
  end

  // Operand/result shift registers, borrow register and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      diff_reg <= '0;
      bin_reg  <= 1'b0;
      cnt_reg  <= '0;
    end else if (accept) begin
      a_reg    <= a;
      b_reg    <= b;
      diff_reg <= '0;
      bin_reg  <= 1'b0;
      cnt_reg  <= '0;
    end else if (state_reg == SHIFT) begin
      a_reg    <= a_reg >> 1;
      b_reg    <= b_reg >> 1;
      diff_reg <= {d_bit, diff_reg[WIDTH-1:1]};
      bin_reg  <= bout;
      cnt_reg  <= cnt_reg + 1'b1;
    end
  end

  // After the last bit the borrow register holds the final borrow-out
  assign diff   = diff_reg;
  assign borrow = bin_reg;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_reg, b_msb_reg, ovf_reg;

  // Operand signs are kept aside because the operand registers shift away;
  // the flag is settled on the same edge that writes the result MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      a_msb_reg <= a[WIDTH-1];
      b_msb_reg <= b[WIDTH-1];
      ovf_reg   <= 1'b0;
    end else if (last_bit) begin
      ovf_reg   <= (a_msb_reg ^ b_msb_reg) & (d_bit ^ a_msb_reg);
    end
  end

  assign ovf = ovf_reg;
`else
  logic unused_last;
  assign unused_last = last_bit;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: directed scoreboard bench for serial_sub_ctrl (WIDTH=8).
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, borrow;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   fail_cnt  = 0;
  int   total_cnt = 0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation: push expectation, strobe start, optionally fire an ignored
  // start in cycle ign_cyc, wait (bounded) for done, pop and compare
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int ign_cyc, input string tag);
    exp_t e;
    exp_t got;
    int   cyc;
    bit   seen;
    e.diff   = av - bv;
    e.borrow = (av < bv);
    e.ovf    = (av[W-1] != bv[W-1]) && (e.diff[W-1] != av[W-1]);
    sb_q.push_back(e);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    check({tag, ":busy_c1"}, 32'(busy), 32'd1);
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (cyc == ign_cyc) begin
        a = 8'd1; b = 8'd2; start = 1'b1;
      end
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
      end
    end
    check({tag, ":done_cycle"}, 32'(cyc), 32'(W + 1));
    got = sb_q.pop_front();
    check({tag, ":diff"}, 32'(diff), 32'(got.diff));
    check({tag, ":borrow"}, 32'(borrow), 32'(got.borrow));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, ":ovf"}, 32'(ovf), 32'(got.ovf));
`endif
    @(posedge clk); #1;
    check({tag, ":busy_idle"}, 32'(busy), 32'd0);
    check({tag, ":done_pulse"}, 32'(done), 32'd0);
    check({tag, ":diff_hold"}, 32'(diff), 32'(got.diff));
    $display("op %s a=%0d b=%0d diff=%0h borrow=%0b done_cycle=%0d", tag, av, bv, diff, borrow, cyc);
  endtask

  initial begin
    logic [W-1:0] held;
    logic         held_b;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    check("rst:diff", 32'(diff), 32'd0);
    check("rst:borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst:ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'd200, 8'd55, -1, "200-55");
    run_op(8'd5, 8'd10, -1, "5-10");
    run_op(8'h80, 8'h01, -1, "80-01");
    run_op(8'hFF, 8'hFF, -1, "FF-FF");
    run_op(8'h00, 8'h01, -1, "00-01_b2b");
    run_op(8'd9, 8'd3, 4, "9-3_ign");
    run_op(8'h7F, 8'hFF, -1, "7F-FF");

    // Result hold in IDLE while inputs wiggle without start
    held   = diff;
    held_b = borrow;
    for (int i = 0; i < 4; i++) begin
      a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
    end
    check("hold:diff", 32'(diff), 32'(held));
    check("hold:borrow", 32'(borrow), 32'(held_b));
    check("hold:busy", 32'(busy), 32'd0);
    $display("hold diff=%0h borrow=%0b", diff, borrow);

    // Asynchronous reset in cycle 4 of an operation
    a = 8'd200; b = 8'd55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst:busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst:busy", 32'(busy), 32'd0);
    check("midrst:done", 32'(done), 32'd0);
    check("midrst:diff", 32'(diff), 32'd0);
    check("midrst:borrow", 32'(borrow), 32'd0);
    @(posedge clk); #1;
    check("midrst:busy_held", 32'(busy), 32'd0);
    rst_n = 1'b1;
    $display("midrst busy=%0b diff=%0h", busy, diff);
    @(posedge clk); #1;
    run_op(8'd100, 8'd1, -1, "100-1_post_rst");

    // A few random operations through the same scoreboard
    for (int i = 0; i < 4; i++) begin
      run_op(W'($urandom), W'($urandom), -1, "rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
